dest_reader: RTL and testbench
==============================

DEST_READER -- requirements
Module: dest_reader

Interface
REQ-001 SHALL have parameter data_width, default 6, the word width of both destination FIFOs.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on posedge clk.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port active_in  input  1  transmission-layer active flag; reading permitted only while high.
REQ-005 SHALL have port burst_max  input  4  maximum consecutive pops from one FIFO before yielding; value 0 treated as 1.
REQ-006 SHALL have port ready_in  input  1  downstream sink accepts a word this cycle.
REQ-007 SHALL have ports data_in_D0, data_in_D1  input  data_width  head word of FIFO D0/D1 (first-word-fall-through, valid while not empty).
REQ-008 SHALL have ports empty_D0, empty_D1  input  1  FIFO D0/D1 empty flags.
REQ-009 SHALL have ports D0_pop, D1_pop  output  1  combinational pop strobes to FIFO D0/D1.
REQ-010 SHALL have port data_out  output  data_width  registered popped word.
REQ-011 SHALL have port valid_out  output  1  data_out holds a word popped the previous cycle.
REQ-012 SHALL have port dest_out  output  1  source of data_out: 0 = D0, 1 = D1.
REQ-013 SHALL have ports count_D0, count_D1  output  8  registered pop counters per FIFO.

Function
REQ-014 SHALL implement an FSM with states IDLE, GRANT_D0, GRANT_D1.
REQ-015 IDLE: if active_in and !empty_D0 -> GRANT_D0; else if active_in and !empty_D1 -> GRANT_D1; else stay; no pops in IDLE.
REQ-016 D0_pop SHALL equal (state==GRANT_D0) & active_in & ready_in & !empty_D0; D1_pop likewise for D1; never both high.
REQ-017 On a pop: data_out <= selected data_in, dest_out <= source, valid_out <= 1 next cycle; cycles without a pop: valid_out <= 0, data_out/dest_out hold.
REQ-018 Latency: empty falls in cycle k from IDLE -> GRANT in k+1, pop in k+1, valid_out in k+2.
REQ-019 4-bit burst counter: cleared on grant entry; +1 per pop; holds when ready_in low.
REQ-020 In GRANT_Dx after a pop with burst count reaching burst_max (or 1 if 0): if other FIFO non-empty -> GRANT of other, counter cleared; else stay, counter cleared.
REQ-021 In GRANT_Dx with current FIFO empty: other non-empty -> GRANT of other; both empty -> IDLE.
REQ-022 In GRANT_Dx with ready_in low: no pop, state and counter held.
REQ-023 active_in low in any state: no pop that cycle, next state IDLE, counter cleared.
REQ-024 count_D0/count_D1 SHALL increment by 1 per respective pop, wrapping 255 -> 0.

Reset
REQ-025 reset high at posedge clk SHALL force state IDLE, burst counter 0, data_out 0, valid_out 0, dest_out 0, count_D0 0, count_D1 0, taking priority over all other inputs.
REQ-026 While reset is high D0_pop and D1_pop SHALL be 0; reset mid-burst SHALL discard the grant with no further pops.

Verification
REQ-027 Reset, active_in=1, ready_in=1, both empty -> D0_pop=D1_pop=0, valid_out=0, state IDLE.
REQ-028 D0 holds 0x30,0x35,0x34, D1 empty, burst_max=2 -> three consecutive D0 pops, data_out 0x30,0x35,0x34 one cycle later with dest_out=0, count_D0=3, then IDLE.
REQ-029 Both FIFOs hold 4 words, burst_max=2 -> pop order D0,D0,D1,D1,D0,D0,D1,D1; count_D0=count_D1=4.
REQ-030 ready_in low 3 cycles mid-burst -> no pops, valid_out=0 for those cycles, burst resumes at held count with no word lost.
REQ-031 active_in dropped during GRANT_D1 -> pops stop same cycle, IDLE next cycle; reasserted -> D0 granted first if non-empty.
REQ-032 256 D0 pops from reset -> count_D0 wraps to 0; synchronous reset mid-burst -> all outputs 0 next cycle.

Source files
------------

// File: rtl/dest_reader_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | dest_reader_if : FIFO-side, sink-side and status signals of dest_reader |
// | rev 1.0                                                            |
// +--------------------------------------------------------------------+
interface dest_reader_if #(
  parameter int data_width = 6
);
  logic                  active_in;
  logic [3:0]            burst_max;
  logic                  ready_in;
  logic [data_width-1:0] data_in_D0;
  logic [data_width-1:0] data_in_D1;
  logic                  empty_D0;
  logic                  empty_D1;
  logic                  D0_pop;
  logic                  D1_pop;
  logic [data_width-1:0] data_out;
  logic                  valid_out;
  logic                  dest_out;
  logic [7:0]            count_D0;
  logic [7:0]            count_D1;

  modport master (
    output active_in, burst_max, ready_in, data_in_D0, data_in_D1, empty_D0, empty_D1,
    input  D0_pop, D1_pop, data_out, valid_out, dest_out, count_D0, count_D1
  );

  modport slave (
    input  active_in, burst_max, ready_in, data_in_D0, data_in_D1, empty_D0, empty_D1,
    output D0_pop, D1_pop, data_out, valid_out, dest_out, count_D0, count_D1
  );
endinterface
`default_nettype wire

// File: rtl/dest_reader.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | dest_reader : burst-limited round-robin reader of two FWFT FIFOs    |
// | rev 1.0                                                            |
// +--------------------------------------------------------------------+
module dest_reader #(
  parameter int data_width = 6
) (
  input wire           clk,
  input wire           reset,
  dest_reader_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    GRANT_D0 = 2'd1,
    GRANT_D1 = 2'd2
  } state_t;

  state_t                state;
  state_t                state_next;
  state_t                other_grant;
  logic [3:0]            burst_cnt;
  logic [3:0]            burst_next;
  logic [3:0]            burst_limit;
  logic [4:0]            burst_inc;
  logic                  own_empty;
  logic                  other_empty;
  logic                  pop_d0;
  logic                  pop_d1;
  logic [data_width-1:0] data_r;
  logic                  valid_r;
  logic                  dest_r;
  logic [7:0]            count_d0_r;
  logic [7:0]            count_d1_r;

  // A burst limit of zero would never let the grant rotate, so it acts as one.
  assign burst_limit = (bus.burst_max == 4'd0) ? 4'd1 : bus.burst_max;
  assign burst_inc   = {1'b0, burst_cnt} + 5'd1;

  // Reset gates the strobes so a grant held in the state register cannot pop.
  assign pop_d0 = !reset && (state == GRANT_D0) && bus.active_in && bus.ready_in && !bus.empty_D0;
  assign pop_d1 = !reset && (state == GRANT_D1) && bus.active_in && bus.ready_in && !bus.empty_D1;

  assign bus.D0_pop    = pop_d0;
  assign bus.D1_pop    = pop_d1;
  assign bus.data_out  = data_r;
  assign bus.valid_out = valid_r;
  assign bus.dest_out  = dest_r;
  assign bus.count_D0  = count_d0_r;
  assign bus.count_D1  = count_d1_r;

  always_comb begin
    own_empty   = bus.empty_D0;
    other_empty = bus.empty_D1;
    other_grant = GRANT_D1;
    if (state == GRANT_D1) begin
      own_empty   = bus.empty_D1;
      other_empty = bus.empty_D0;
      other_grant = GRANT_D0;
    end
  end

  always_comb begin
    state_next = state;
    burst_next = burst_cnt;
    case (state)
      IDLE: begin
        burst_next = 4'd0;
        if (bus.active_in && !bus.empty_D0) begin
          state_next = GRANT_D0;
        end else if (bus.active_in && !bus.empty_D1) begin
          state_next = GRANT_D1;
        end
      end
      GRANT_D0, GRANT_D1: begin
        if (!bus.active_in) begin
          state_next = IDLE;
          burst_next = 4'd0;
        end else if (own_empty) begin
          state_next = other_empty ? IDLE : other_grant;
          burst_next = 4'd0;
        end else if (bus.ready_in) begin
          // This cycle pops; rotate only once the burst limit is reached.
          if (burst_inc >= {1'b0, burst_limit}) begin
            burst_next = 4'd0;
            if (!other_empty) begin
              state_next = other_grant;
            end
          end else begin
            burst_next = burst_inc[3:0];
          end
        end
      end
      default: begin
        state_next = IDLE;
        burst_next = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      burst_cnt  <= 4'd0;
      data_r     <= '0;
      valid_r    <= 1'b0;
      dest_r     <= 1'b0;
      count_d0_r <= 8'd0;
      count_d1_r <= 8'd0;
    end else begin
      state     <= state_next;
      burst_cnt <= burst_next;
      valid_r   <= pop_d0 | pop_d1;
      if (pop_d0) begin
        data_r     <= bus.data_in_D0;
        dest_r     <= 1'b0;
        count_d0_r <= count_d0_r + 8'd1;
      end
      if (pop_d1) begin
        data_r     <= bus.data_in_D1;
        dest_r     <= 1'b1;
        count_d1_r <= count_d1_r + 8'd1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dest_reader.sv
`default_nettype none
// tb_dest_reader : directed and randomized checks of dest_reader against a
// queue-based model of the two FIFOs and the grant/burst rules.
module tb_dest_reader;
  localparam int DW = 6;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  dest_reader_if #(.data_width(DW)) bus ();
  dest_reader #(.data_width(DW)) dut (.clk(clk), .reset(reset), .bus(bus.slave));

  logic [DW-1:0] q0[$];
  logic [DW-1:0] q1[$];
  int            gsrc;
  int            used;
  logic [DW-1:0] m_data;
  logic          m_valid;
  logic          m_dest;
  logic [7:0]    m_c0;
  logic [7:0]    m_c1;
  int            obs_order[$];
  logic [DW-1:0] out_log[$];
  logic [DW-1:0] pushed[$];
  int            tests = 0;
  int            fails = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_fifos();
    bus.empty_D0   = (q0.size() == 0);
    bus.data_in_D0 = (q0.size() != 0) ? q0[0] : '0;
    bus.empty_D1   = (q1.size() == 0);
    bus.data_in_D1 = (q1.size() != 0) ? q1[0] : '0;
  endtask

  task automatic push0(input logic [DW-1:0] v);
    q0.push_back(v);
    drive_fifos();
  endtask

  task automatic push1(input logic [DW-1:0] v);
    q1.push_back(v);
    drive_fifos();
  endtask

  // One clock: check the pop strobes, advance the model, check registered outputs.
  task automatic step();
    int  pop_src;
    int  lim;
    bit  e0, e1, own_e, oth_e;
    drive_fifos();
    #1;
    e0 = (q0.size() == 0);
    e1 = (q1.size() == 0);
    own_e = (gsrc == 1) ? e1 : e0;
    oth_e = (gsrc == 1) ? e0 : e1;
    pop_src = -1;
    if (!reset && gsrc >= 0 && bus.active_in && bus.ready_in && !own_e) pop_src = gsrc;
    check("D0_pop", {31'd0, bus.D0_pop}, {31'd0, pop_src == 0});
    check("D1_pop", {31'd0, bus.D1_pop}, {31'd0, pop_src == 1});
    if (bus.D0_pop === 1'b1) obs_order.push_back(0);
    if (bus.D1_pop === 1'b1) obs_order.push_back(1);
    @(posedge clk);
    if (reset) begin
      gsrc = -1; used = 0;
      m_data = '0; m_valid = 1'b0; m_dest = 1'b0; m_c0 = 8'd0; m_c1 = 8'd0;
    end else begin
      m_valid = (pop_src >= 0);
      if (pop_src == 0) begin
        m_data = q0.pop_front(); m_dest = 1'b0; m_c0 = m_c0 + 8'd1;
      end else if (pop_src == 1) begin
        m_data = q1.pop_front(); m_dest = 1'b1; m_c1 = m_c1 + 8'd1;
      end
      lim = (bus.burst_max == 4'd0) ? 1 : int'(bus.burst_max);
      if (!bus.active_in) begin
        gsrc = -1; used = 0;
      end else if (gsrc < 0) begin
        used = 0;
        if (!e0) gsrc = 0;
        else if (!e1) gsrc = 1;
      end else if (own_e) begin
        used = 0;
        gsrc = oth_e ? -1 : 1 - gsrc;
      end else if (bus.ready_in) begin
        used++;
        if (used >= lim) begin
          used = 0;
          if (!oth_e) gsrc = 1 - gsrc;
        end
      end
    end
    #1;
    check("valid_out", {31'd0, bus.valid_out}, {31'd0, m_valid});
    check("data_out", {{(32-DW){1'b0}}, bus.data_out}, {{(32-DW){1'b0}}, m_data});
    check("dest_out", {31'd0, bus.dest_out}, {31'd0, m_dest});
    check("count_D0", {24'd0, bus.count_D0}, {24'd0, m_c0});
    check("count_D1", {24'd0, bus.count_D1}, {24'd0, m_c1});
    if (bus.valid_out === 1'b1) out_log.push_back(bus.data_out);
    drive_fifos();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    logic [DW-1:0] v;
    gsrc = -1; used = 0;
    m_data = '0; m_valid = 1'b0; m_dest = 1'b0; m_c0 = 8'd0; m_c1 = 8'd0;
    reset = 1'b1;
    bus.active_in = 1'b1;
    bus.ready_in  = 1'b1;
    bus.burst_max = 4'd2;
    drive_fifos();

    // Reset, then both FIFOs empty while active and ready: nothing happens.
    step(); step();
    reset = 1'b0;
    repeat (3) step();

    // Three words in D0 only, burst limit 2: consecutive pops then idle.
    obs_order.delete(); out_log.delete();
    push0(6'h30); push0(6'h35); push0(6'h34);
    repeat (6) step();
    check("r028_npops", obs_order.size(), 3);
    check("r028_w0", {26'd0, out_log[0]}, 32'h30);
    check("r028_w1", {26'd0, out_log[1]}, 32'h35);
    check("r028_w2", {26'd0, out_log[2]}, 32'h34);
    check("r028_cnt0", {24'd0, bus.count_D0}, 32'd3);

    // Four words in each FIFO, burst limit 2: alternating pairs.
    obs_order.delete();
    for (int i = 0; i < 4; i++) begin
      push0(DW'($urandom_range(0, 63)));
      push1(DW'($urandom_range(0, 63)));
    end
    repeat (12) step();
    check("r029_npops", obs_order.size(), 8);
    for (int i = 0; i < 8; i++) check("r029_order", obs_order[i], (i / 2) % 2);
    check("r029_cnt0", {24'd0, bus.count_D0}, 32'd7);
    check("r029_cnt1", {24'd0, bus.count_D1}, 32'd4);

    // Ready stalls mid-burst: no word lost, burst resumes.
    out_log.delete(); pushed.delete();
    bus.burst_max = 4'd4;
    for (int i = 0; i < 6; i++) begin
      v = DW'($urandom_range(0, 63));
      pushed.push_back(v);
      push0(v);
    end
    repeat (3) step();
    bus.ready_in = 1'b0;
    repeat (3) step();
    bus.ready_in = 1'b1;
    repeat (8) step();
    check("r030_nwords", out_log.size(), 6);
    for (int i = 0; i < 6; i++) check("r030_word", {26'd0, out_log[i]}, {26'd0, pushed[i]});

    // Drop active during a D1 grant, then reassert: D0 is granted first.
    bus.burst_max = 4'd2;
    for (int i = 0; i < 6; i++) begin
      push0(DW'($urandom_range(0, 63)));
      push1(DW'($urandom_range(0, 63)));
    end
    n = 0;
    while (gsrc != 1 && n < 20) begin step(); n++; end
    check("r031_reach_d1", {31'd0, gsrc == 1}, 32'd1);
    bus.active_in = 1'b0;
    step();
    bus.active_in = 1'b1;
    obs_order.delete();
    step(); step();
    check("r031_regrant", obs_order.size() > 0 ? obs_order[0] : -1, 0);
    repeat (24) step();

    // Randomized traffic including occasional resets.
    for (int c = 0; c < 500; c++) begin
      if (q0.size() < 8 && $urandom_range(0, 2) == 0) push0(DW'($urandom_range(0, 63)));
      if (q1.size() < 8 && $urandom_range(0, 2) == 0) push1(DW'($urandom_range(0, 63)));
      bus.active_in = ($urandom_range(0, 9) != 0);
      bus.ready_in  = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 15) == 0) bus.burst_max = 4'($urandom_range(0, 15));
      reset = ($urandom_range(0, 199) == 0);
      step();
    end
    reset = 1'b0;
    bus.active_in = 1'b1;
    bus.ready_in  = 1'b1;

    // 256 D0 pops from reset wrap the counter; then reset mid-burst.
    q0.delete(); q1.delete();
    reset = 1'b1;
    step();
    reset = 1'b0;
    bus.burst_max = 4'd0;
    obs_order.delete();
    for (int i = 0; i < 256; i++) q0.push_back(DW'($urandom_range(0, 63)));
    n = 0;
    while (q0.size() > 0 && n < 400) begin step(); n++; end
    repeat (2) step();
    check("r032_npops", obs_order.size(), 256);
    check("r032_wrap", {24'd0, bus.count_D0}, 32'd0);
    bus.burst_max = 4'd3;
    for (int i = 0; i < 4; i++) begin
      push0(DW'($urandom_range(1, 63)));
      push1(DW'($urandom_range(1, 63)));
    end
    repeat (3) step();
    reset = 1'b1;
    step();
    check("r032_rst_valid", {31'd0, bus.valid_out}, 32'd0);
    check("r032_rst_data", {26'd0, bus.data_out}, 32'd0);
    check("r032_rst_dest", {31'd0, bus.dest_out}, 32'd0);
    check("r032_rst_c0", {24'd0, bus.count_D0}, 32'd0);
    check("r032_rst_c1", {24'd0, bus.count_D1}, 32'd0);
    check("r032_rst_pop0", {31'd0, bus.D0_pop}, 32'd0);
    check("r032_rst_pop1", {31'd0, bus.D1_pop}, 32'd0);
    reset = 1'b0;
    repeat (12) step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
`default_nettype wire
